// File: rtl/obf_key_loader.sv
// Serial key loader for the locked c432 core: shifts X/p key bits into a shadow register and
// commits them atomically to the active key. Define KEY_PARITY_CHECK_EN to require a trailing even-parity bit.
module obf_key_loader #(
    parameter int KEY_W  = 88,
    parameter int PROG_W = 4,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              key_clear,
    input  logic              key_bit,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [KEY_W-1:0]  x_key,
    output logic [PROG_W-1:0] p_key,
    output logic              key_active
);

    localparam int TOT = KEY_W + PROG_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PARITY,
        ST_COMMIT,
        ST_ERROR
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [TOT-1:0]    shadow_reg;
    logic [KEY_W-1:0]  x_key_reg;
    logic [PROG_W-1:0] p_key_reg;
    logic              key_active_reg;
    logic              key_ready_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              xfer;
    logic              last_bit;
    logic              loading;

    assign xfer     = key_valid && key_ready_reg;
    assign last_bit = (cnt_reg == CNT_W'(TOT - 1));
    assign loading  = (state_reg == ST_LOAD) || (state_reg == ST_PARITY);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (start) begin
                    state_next = ST_LOAD;
                end else if (xfer && last_bit) begin
`ifdef KEY_PARITY_CHECK_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_COMMIT;
`endif
                end
            end
`ifdef KEY_PARITY_CHECK_EN
            ST_PARITY: begin
                if (start) begin
                    state_next = ST_LOAD;
                end else if (xfer) begin
                    // Even parity across all key bits plus the trailing parity bit.
                    state_next = ((^shadow_reg) ^ key_bit) ? ST_ERROR : ST_COMMIT;
                end
            end
            ST_ERROR:  state_next = ST_IDLE;
`endif
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            shadow_reg     <= '0;
            x_key_reg      <= '0;
            p_key_reg      <= '0;
            key_active_reg <= 1'b0;
            key_ready_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            busy_reg      <= (state_next != ST_IDLE);
            key_ready_reg <= (state_next == ST_LOAD) || (state_next == ST_PARITY);
            done_reg      <= (state_reg == ST_COMMIT);

            // A start during a load restarts it and drops any bit offered that cycle.
            if (start && (state_reg == ST_IDLE || loading)) begin
                cnt_reg <= '0;
            end else if (state_reg == ST_LOAD && xfer) begin
                cnt_reg    <= cnt_reg + 1'b1;
                shadow_reg <= {key_bit, shadow_reg[TOT-1:1]};
            end

            if (key_clear) begin
                x_key_reg      <= '0;
                p_key_reg      <= '0;
                key_active_reg <= 1'b0;
            end else if (state_reg == ST_COMMIT) begin
                x_key_reg      <= shadow_reg[KEY_W-1:0];
                p_key_reg      <= shadow_reg[TOT-1:KEY_W];
                key_active_reg <= 1'b1;
            end
        end
    end

`ifdef KEY_PARITY_CHECK_EN
    logic err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (start && (state_reg == ST_IDLE || loading)) begin
            err_reg <= 1'b0;
        end else if (state_reg == ST_ERROR) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign key_ready  = key_ready_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign x_key      = x_key_reg;
    assign p_key      = p_key_reg;
    assign key_active = key_active_reg;

endmodule
